// File: rtl/pipelined_addsub.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshakes.
// Each N/STAGES slice is resolved in its own stage, and the inter-slice carry is registered.
module pipelined_addsub #(
  parameter int unsigned N      = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         FLUSH,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         ADD_SUB,
  input  logic         USE_CIN,
  input  logic         CIN,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [N-1:0] R,
  output logic         COUT,
  output logic         OVF,
  output logic         ZERO,
  output logic         NEG
);

  localparam int unsigned W = N / STAGES;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         c_msb;
    logic         c_out;
  } slice_t;

  // Generate/propagate carry recurrence is confined to one slice.
  function automatic slice_t slice_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin);
    slice_t       res;
    logic [W:0]   c;
    logic [W-1:0] g;
    logic [W-1:0] p;
    g    = a & b;
    p    = a | b;
    c    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < W; i++) c[i+1] = g[i] | (p[i] & c[i]);
    res.sum   = a ^ b ^ c[W-1:0];
    res.c_msb = c[W-1];
    res.c_out = c[W];
    return res;
  endfunction

  logic [N-1:0] a_q [STAGES];
  logic [N-1:0] b_q [STAGES];
  logic [N-1:0] r_q [STAGES];
  logic         c_q [STAGES];
  logic         z_q [STAGES];
  logic         v_q [STAGES];
  logic         ovf_q;

  logic [N-1:0] a_d [STAGES];
  logic [N-1:0] b_d [STAGES];
  logic [N-1:0] r_d [STAGES];
  logic         c_d [STAGES];
  logic         z_d [STAGES];
  logic         ovf_d;
  logic         advance;

  assign advance  = !v_q[STAGES-1] || OUT_READY;
  assign IN_READY = !FLUSH && advance;

  always_comb begin
    logic [N-1:0] src_a;
    logic [N-1:0] src_b;
    logic [N-1:0] src_r;
    slice_t       s;
    src_a = A;
    src_b = B ^ {N{ADD_SUB}};
    src_r = '0;
    s     = slice_add(src_a[W-1:0], src_b[W-1:0], USE_CIN ? CIN : ADD_SUB);
    src_r[W-1:0] = s.sum;
    a_d[0] = src_a;
    b_d[0] = src_b;
    r_d[0] = src_r;
    c_d[0] = s.c_out;
    z_d[0] = (s.sum == '0);
    // Operands ride along skewed; finished low slices are carried forward in r.
    for (int unsigned k = 1; k < STAGES; k++) begin
      src_a = a_q[k-1];
      src_b = b_q[k-1];
      src_r = r_q[k-1];
      s     = slice_add(src_a[k*W +: W], src_b[k*W +: W], c_q[k-1]);
      src_r[k*W +: W] = s.sum;
      a_d[k] = src_a;
      b_d[k] = src_b;
      r_d[k] = src_r;
      c_d[k] = s.c_out;
      z_d[k] = z_q[k-1] && (s.sum == '0);
    end
    ovf_d = s.c_msb ^ s.c_out;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
        c_q[k] <= 1'b0;
        z_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else begin
      if (FLUSH) begin
        for (int unsigned k = 0; k < STAGES; k++) v_q[k] <= 1'b0;
      end else if (advance) begin
        v_q[0] <= IN_VALID;
        for (int unsigned k = 1; k < STAGES; k++) v_q[k] <= v_q[k-1];
      end
      if (advance) begin
        for (int unsigned k = 0; k < STAGES; k++) begin
          a_q[k] <= a_d[k];
          b_q[k] <= b_d[k];
          r_q[k] <= r_d[k];
          c_q[k] <= c_d[k];
          z_q[k] <= z_d[k];
        end
        ovf_q <= ovf_d;
      end
    end
  end

  assign OUT_VALID = v_q[STAGES-1];
  assign R         = r_q[STAGES-1];
  assign COUT      = c_q[STAGES-1];
  assign ZERO      = z_q[STAGES-1];
  assign NEG       = r_q[STAGES-1][N-1];
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: accepted beats queue an arithmetic-model result,
// and a monitor compares each presented output beat against the queue head.
`timescale 1ns/1ps
module tb_pipelined_addsub;
  localparam int unsigned N      = 32;
  localparam int unsigned STAGES = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          FLUSH = 1'b0;
  logic          IN_VALID = 1'b0;
  logic          IN_READY;
  logic [N-1:0]  A = '0;
  logic [N-1:0]  B = '0;
  logic          ADD_SUB = 1'b0;
  logic          USE_CIN = 1'b0;
  logic          CIN = 1'b0;
  logic          OUT_VALID;
  logic          OUT_READY = 1'b1;
  logic [N-1:0]  R;
  logic          COUT, OVF, ZERO, NEG;

  pipelined_addsub #(.N(N), .STAGES(STAGES)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .ADD_SUB(ADD_SUB), .USE_CIN(USE_CIN), .CIN(CIN),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .R(R), .COUT(COUT), .OVF(OVF),
    .ZERO(ZERO), .NEG(NEG)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] r;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   retired = 0;
  bit   acc_p = 1'b0;
  bit   flush_p = 1'b0;
  res_t acc_exp;

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic as, input logic uc, input logic ci);
    res_t        e;
    logic [31:0] be;
    logic        c0;
    logic [32:0] s;
    be     = as ? ~b : b;
    c0     = uc ? ci : as;
    s      = {1'b0, a} + {1'b0, be} + {32'd0, c0};
    e.r    = s[31:0];
    e.cout = s[32];
    e.ovf  = (a[31] == be[31]) && (s[31] != a[31]);
    e.zero = (s[31:0] == 32'd0);
    e.neg  = s[31];
    return e;
  endfunction

  function automatic res_t dut_res();
    res_t g;
    g.r = R; g.cout = COUT; g.ovf = OVF; g.zero = ZERO; g.neg = NEG;
    return g;
  endfunction

  task automatic check_res(input string name, input res_t got, input res_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got r=%h c=%b o=%b z=%b n=%b expected r=%h c=%b o=%b z=%b n=%b",
               name, got.r, got.cout, got.ovf, got.zero, got.neg,
               exp.r, exp.cout, exp.ovf, exp.zero, exp.neg);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Acceptance and flush are decided by what is stable before the coming edge.
  always @(negedge CLK) begin
    acc_p   = !RST && IN_VALID && IN_READY;
    flush_p = !RST && FLUSH;
    acc_exp = model(A, B, ADD_SUB, USE_CIN, CIN);
    if (!RST)
      check_val("in_ready_rule", {31'd0, IN_READY}, {31'd0, !FLUSH && (!OUT_VALID || OUT_READY)});
  end

  always @(posedge CLK) begin
    if (flush_p) exp_q.delete();
    else if (acc_p) exp_q.push_back(acc_exp);
    acc_p   = 1'b0;
    flush_p = 1'b0;
  end

  // Monitor: retire on OUT_VALID & OUT_READY, verify hold while stalled.
  always @(negedge CLK) begin
    if (!RST && OUT_VALID) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output got r=%h expected no beat", R);
      end else if (OUT_READY) begin
        check_res("result", dut_res(), exp_q.pop_front());
        retired++;
      end else begin
        check_res("stall_hold", dut_res(), exp_q[0]);
      end
    end
  end

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 2) == 0) begin
      case ($urandom_range(0, 5))
        0: v = 32'h0000_0000;
        1: v = 32'hFFFF_FFFF;
        2: v = 32'h7FFF_FFFF;
        3: v = 32'h8000_0000;
        4: v = 32'h0000_FFFF;
        default: v = 32'h0000_0001;
      endcase
    end
    return v;
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic as, input logic uc, input logic ci);
    int g;
    g = 0;
    A = a; B = b; ADD_SUB = as; USE_CIN = uc; CIN = ci; IN_VALID = 1'b1;
    @(negedge CLK);
    while (!IN_READY && g < 50) begin
      @(negedge CLK);
      g++;
    end
    if (!IN_READY) begin
      checks++;
      failures++;
      $display("FAIL send_timeout got in_ready=0 expected 1 within 50 cycles");
    end
    @(posedge CLK);
    #1 IN_VALID = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    IN_VALID  = 1'b0;
    FLUSH     = 1'b0;
    OUT_READY = 1'b1;
    while ((exp_q.size() != 0 || OUT_VALID) && g < 30) begin
      @(posedge CLK);
      #1 g++;
    end
    check_val("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Issued into an empty pipeline; checks latency and literal expected values.
  task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic as, input logic uc, input logic ci,
                          input logic [31:0] er, input logic ec, input logic eo,
                          input logic ez, input logic en);
    int   lat;
    res_t e;
    A = a; B = b; ADD_SUB = as; USE_CIN = uc; CIN = ci; IN_VALID = 1'b1; OUT_READY = 1'b1;
    @(posedge CLK);
    #1 IN_VALID = 1'b0;
    lat = 1;
    while (!OUT_VALID && lat < 12) begin
      @(posedge CLK);
      #1 lat++;
    end
    check_val({name, "_latency"}, 32'(lat), 32'(STAGES));
    e.r = er; e.cout = ec; e.ovf = eo; e.zero = ez; e.neg = en;
    check_res(name, dut_res(), e);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   base;
    res_t zero_res;
    zero_res = '0;

    #7;
    check_val("reset_out_valid", {31'd0, OUT_VALID}, 32'd0);
    check_res("reset_outputs", dut_res(), zero_res);
    #5 RST = 1'b0;
    @(posedge CLK);
    #1 check_val("ready_after_reset", {31'd0, IN_READY}, 32'd1);

    directed("add_wrap",     32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 0, 32'h0000_0000, 1, 0, 1, 0);
    directed("slice_carry",  32'h0000_FFFF, 32'h0000_0001, 0, 0, 0, 32'h0001_0000, 0, 0, 0, 0);
    directed("add_ovf",      32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 0, 32'h8000_0000, 0, 1, 0, 1);
    directed("sub_ovf",      32'h8000_0000, 32'h0000_0001, 1, 0, 0, 32'h7FFF_FFFF, 1, 1, 0, 0);
    directed("chain_low",    32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 0, 32'h0000_0000, 1, 0, 1, 0);
    directed("chain_high",   32'h0000_0000, 32'h0000_0000, 0, 1, 1, 32'h0000_0001, 0, 0, 0, 0);
    directed("chain_borrow", 32'h0000_0005, 32'h0000_0003, 1, 1, 0, 32'h0000_0001, 1, 0, 0, 0);

    // Eight back-to-back beats with a three-cycle output stall.
    base = retired;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
      begin
        repeat (6) @(posedge CLK);
        #1 OUT_READY = 1'b0;
        repeat (3) begin
          @(negedge CLK);
          check_val("in_ready_stalled", {31'd0, IN_READY}, 32'd0);
        end
        @(posedge CLK);
        #1 OUT_READY = 1'b1;
      end
    join
    drain();
    check_val("stall_beats_retired", 32'(retired - base), 32'd8);

    // Flush with three beats in flight; a beat offered alongside FLUSH is refused.
    base = retired;
    for (int i = 0; i < 3; i++) send(pick_operand(), pick_operand(), 1'b0, 1'b0, 1'b0);
    FLUSH = 1'b1;
    IN_VALID = 1'b1;
    A = 32'h1234_5678;
    @(posedge CLK);
    #1 FLUSH = 1'b0;
    IN_VALID = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check_val("flush_no_output", {31'd0, OUT_VALID}, 32'd0);
      @(posedge CLK);
      #1;
    end
    check_val("flush_beats_retired", 32'(retired - base), 32'd0);
    drain();

    // Randomized traffic with backpressure, bubbles and occasional flushes.
    for (int i = 0; i < 400; i++) begin
      IN_VALID  = ($urandom_range(0, 3) != 0);
      OUT_READY = ($urandom_range(0, 3) != 0);
      FLUSH     = ($urandom_range(0, 39) == 0);
      A         = pick_operand();
      B         = pick_operand();
      ADD_SUB   = 1'($urandom_range(0, 1));
      USE_CIN   = 1'($urandom_range(0, 1));
      CIN       = 1'($urandom_range(0, 1));
      @(posedge CLK);
      #1;
    end
    drain();

    // Asynchronous reset pulse mid-cycle while a stream is running.
    OUT_READY = 1'b1;
    for (int i = 0; i < 6; i++) begin
      A = pick_operand();
      B = pick_operand();
      ADD_SUB = 1'b0;
      USE_CIN = 1'b0;
      IN_VALID = 1'b1;
      @(posedge CLK);
      #1;
    end
    #2 RST = 1'b1;
    IN_VALID = 1'b0;
    #0.5;
    check_val("async_reset_out_valid", {31'd0, OUT_VALID}, 32'd0);
    check_res("async_reset_outputs", dut_res(), zero_res);
    #0.5 RST = 1'b0;
    exp_q.delete();
    #0.1 check_val("ready_after_async_reset", {31'd0, IN_READY}, 32'd1);
    @(posedge CLK);
    #1;
    directed("post_reset_add", 32'h0000_0010, 32'h0000_0020, 0, 0, 0, 32'h0000_0030, 0, 0, 0, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
